// File: rtl/dbus_access.sv
// dbus_access: data-bus access unit placed directly after the memory stage.
// It turns the M-stage load/store into exactly one bus transaction. While the
// access is outstanding it holds the pipeline. For stores it drives byte
// strobes and replicated write data. For loads it returns shifted and
// extended read data.
//
// Optional feature: define MISALIGN_CHECK_EN to flag misaligned half/word
// accesses on addr_err_o. Such an access is not issued. Without the macro,
// the low address bits are forced to the natural alignment instead.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   d_valid_i           M stage holds a load or store
//   write_i             1 = store, 0 = load
//   addr_i              byte address (ALU result)
//   wdata_i             forwarded store data
//   size_i              0 = byte, 1 = half, 2 = word
//   signed_i            sign-extend load data
//   pipe_adv_i          M-stage instruction leaves this cycle
//   flush_i             kill the M-stage instruction
//   stall_o             access outstanding, hold the pipeline
//   rdata_o             extended load data
//   dreq_*              bus request channel (valid/addr/size/strobe/data)
//   dresp_*             bus response channel (addr_ok/data_ok/data)
//   addr_err_o          misaligned access (optional feature only)
module dbus_access #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  d_valid_i,
  input  logic                  write_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  input  logic                  pipe_adv_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  dreq_valid,
  output logic [ADDR_W-1:0]     dreq_addr,
  output logic [1:0]            dreq_size,
  output logic [DATA_W/8-1:0]   dreq_strobe,
  output logic [DATA_W-1:0]     dreq_data,
  input  logic                  dresp_addr_ok,
  input  logic                  dresp_data_ok,
  input  logic [DATA_W-1:0]     dresp_data,
  output logic                  addr_err_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [1:0]  SZ_BYTE = 2'd0;
  localparam logic [1:0]  SZ_HALF = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                killed_q, killed_d;
  logic [DATA_W-1:0]   held_q, held_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [1:0]          req_size_q, req_size_d;
  logic [STRB_W-1:0]   req_strobe_q, req_strobe_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic                req_signed_q, req_signed_d;
  logic                req_write_q, req_write_d;

  logic [1:0]          off_c;
  logic [ADDR_W-1:0]   addr_al_c;
  logic [STRB_W-1:0]   strobe_c;
  logic [DATA_W-1:0]   wdata_fmt_c;
  logic                misalign_c;
  logic                issue_c;
  logic                both_ok_c;
  logic                done_c;
  logic                idle_c;
  logic [1:0]          cur_off_c;
  logic [1:0]          cur_size_c;
  logic                cur_sgn_c;
  logic                cur_write_c;
  logic [DATA_W-1:0]   shifted_c;
  logic [DATA_W-1:0]   ext_c;

  // Store formatting from the live inputs; low offset bits are forced to alignment
  always_comb begin
    off_c       = addr_i[1:0];
    strobe_c    = '1;
    wdata_fmt_c = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        strobe_c    = 4'b0001 << off_c;
        wdata_fmt_c = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        off_c[0]    = 1'b0;
        strobe_c    = 4'b0011 << off_c;
        wdata_fmt_c = {2{wdata_i[15:0]}};
      end
      default: begin
        off_c       = 2'b00;
        strobe_c    = '1;
        wdata_fmt_c = wdata_i;
      end
    endcase
    addr_al_c = {addr_i[ADDR_W-1:2], off_c};
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign_c = ((size_i == SZ_HALF) && addr_i[0]) ||
                      ((size_i != SZ_BYTE) && (size_i != SZ_HALF) && (addr_i[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign idle_c     = (state_q == S_IDLE);
  // resetn gates the combinational issue path so outputs read 0 during reset
  assign issue_c    = resetn && idle_c && d_valid_i && !flush_i && !misalign_c;
  assign addr_err_o = resetn && idle_c && d_valid_i && !flush_i && misalign_c;
  assign both_ok_c  = dresp_addr_ok && dresp_data_ok;

  // Load extraction uses the live request in IDLE, the captured one afterwards
  always_comb begin
    cur_off_c   = idle_c ? off_c    : req_addr_q[1:0];
    cur_size_c  = idle_c ? size_i   : req_size_q;
    cur_sgn_c   = idle_c ? signed_i : req_signed_q;
    cur_write_c = idle_c ? write_i  : req_write_q;
    shifted_c   = dresp_data >> {cur_off_c, 3'b000};
    case (cur_size_c)
      SZ_BYTE: ext_c = {{(DATA_W-8){cur_sgn_c & shifted_c[7]}}, shifted_c[7:0]};
      SZ_HALF: ext_c = {{(DATA_W-16){cur_sgn_c & shifted_c[15]}}, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    killed_d     = killed_q;
    held_d       = held_q;
    req_addr_d   = req_addr_q;
    req_size_d   = req_size_q;
    req_strobe_d = req_strobe_q;
    req_data_d   = req_data_q;
    req_signed_d = req_signed_q;
    req_write_d  = req_write_q;
    done_c       = 1'b0;
    stall_o      = 1'b0;
    dreq_valid   = 1'b0;
    dreq_addr    = '0;
    dreq_size    = '0;
    dreq_strobe  = '0;
    dreq_data    = '0;
    rdata_o      = held_q;

    case (state_q)
      S_IDLE: begin
        if (issue_c) begin
          dreq_valid   = 1'b1;
          dreq_addr    = addr_al_c;
          dreq_size    = size_i;
          dreq_strobe  = write_i ? strobe_c : '0;
          dreq_data    = write_i ? wdata_fmt_c : '0;
          req_addr_d   = addr_al_c;
          req_size_d   = size_i;
          req_strobe_d = write_i ? strobe_c : '0;
          req_data_d   = write_i ? wdata_fmt_c : '0;
          req_signed_d = signed_i;
          req_write_d  = write_i;
          if (both_ok_c) begin
            done_c = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = dresp_addr_ok ? S_DATA : S_ADDR;
          end
        end
      end
      S_ADDR: begin
        dreq_valid  = 1'b1;
        dreq_addr   = req_addr_q;
        dreq_size   = req_size_q;
        dreq_strobe = req_strobe_q;
        dreq_data   = req_data_q;
        if (flush_i) killed_d = 1'b1;
        if (both_ok_c) begin
          done_c = 1'b1;
        end else begin
          stall_o = 1'b1;
          if (dresp_addr_ok) state_d = S_DATA;
        end
      end
      S_DATA: begin
        dreq_addr   = req_addr_q;
        dreq_size   = req_size_q;
        dreq_strobe = req_strobe_q;
        dreq_data   = req_data_q;
        if (flush_i) killed_d = 1'b1;
        if (dresp_data_ok) done_c = 1'b1;
        else               stall_o = 1'b1;
      end
      S_HOLD: begin
        // Result already taken; wait for the instruction to leave without reissuing
        if (pipe_adv_i || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A killed access still completes on the bus, but its data is dropped
    if (done_c) begin
      if (killed_q || flush_i) begin
        state_d = S_IDLE;
      end else begin
        if (!cur_write_c) begin
          held_d  = ext_c;
          rdata_o = ext_c;
        end
        state_d = pipe_adv_i ? S_IDLE : S_HOLD;
      end
    end

    if (state_d == S_IDLE) killed_d = 1'b0;
  end

  // State and request registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      killed_q     <= 1'b0;
      held_q       <= '0;
      req_addr_q   <= '0;
      req_size_q   <= '0;
      req_strobe_q <= '0;
      req_data_q   <= '0;
      req_signed_q <= 1'b0;
      req_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      killed_q     <= killed_d;
      held_q       <= held_d;
      req_addr_q   <= req_addr_d;
      req_size_q   <= req_size_d;
      req_strobe_q <= req_strobe_d;
      req_data_q   <= req_data_d;
      req_signed_q <= req_signed_d;
      req_write_q  <= req_write_d;
    end
  end

endmodule

// File: tb/tb_dbus_access.sv
// Self-checking bench for dbus_access: table of single accesses with bus
// latencies plus hand sequences for flush, reset and alignment handling.
module tb_dbus_access;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        d_valid_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [1:0]  size_i = '0;
  logic        signed_i = 1'b0;
  logic        pipe_adv_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  logic        addr_err_o;

  dbus_access dut (
    .clk(clk), .resetn(resetn), .d_valid_i(d_valid_i), .write_i(write_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i), .signed_i(signed_i),
    .pipe_adv_i(pipe_adv_i), .flush_i(flush_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rsp;
    int          ao;
    int          dl;
    int          hold;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
  } sb_t;

  sb_t         sb_q[$];
  vec_t        vecs[10];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
  endtask

  task automatic drive_idle();
    d_valid_i = 1'b0; flush_i = 1'b0; pipe_adv_i = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'hDEAD_BEEF;
  endtask

  task automatic check_idle(input string nm);
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(dreq_valid), 32'd0);
    chk({nm, "_stall"}, 32'(stall_o), 32'd0);
    chk({nm, "_rdata"}, rdata_o, last_rdata);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  ao_at;
    int  do_at;
    sb_t e;
    ao_at   = v.ao;
    do_at   = v.ao + v.dl;
    e.rdata = v.wr ? last_rdata : v.e_rdata;
    sb_q.push_back(e);
    for (int k = 0; k <= do_at; k++) begin
      @(posedge clk); #1;
      d_valid_i = 1'b1; write_i = v.wr; addr_i = v.addr; wdata_i = v.wdata;
      size_i = v.size; signed_i = v.sgn; flush_i = 1'b0;
      dresp_addr_ok = (k == ao_at);
      dresp_data_ok = (k == do_at);
      dresp_data    = (k == do_at) ? v.rsp : 32'hDEAD_BEEF;
      pipe_adv_i    = (k == do_at) && (v.hold == 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid_c%0d", idx, k), 32'(dreq_valid), 32'(k <= ao_at));
      chk($sformatf("v%0d_stall_c%0d", idx, k), 32'(stall_o), 32'(k < do_at));
      if (k <= ao_at) begin
        chk($sformatf("v%0d_addr_c%0d", idx, k), dreq_addr, v.e_addr);
        chk($sformatf("v%0d_size_c%0d", idx, k), 32'(dreq_size), 32'(v.size));
        chk($sformatf("v%0d_strb_c%0d", idx, k), 32'(dreq_strobe), 32'(v.e_strb));
        chk($sformatf("v%0d_data_c%0d", idx, k), dreq_data, v.e_data);
      end
      if (k == do_at) begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_rdata", idx), rdata_o, e.rdata);
        if (!v.wr) last_rdata = v.e_rdata;
      end
    end
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'hDEAD_BEEF;
      pipe_adv_i = (h == v.hold - 1);
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid%0d", idx, h), 32'(dreq_valid), 32'd0);
      chk($sformatf("v%0d_hold_stall%0d", idx, h), 32'(stall_o), 32'd0);
      chk($sformatf("v%0d_hold_rdata%0d", idx, h), rdata_o, last_rdata);
    end
    check_idle($sformatf("v%0d_idle", idx));
  endtask

  initial begin
    // wr, addr, wdata, size, sgn, rsp, ao, dl, hold, e_addr, e_strb, e_data, e_rdata
    vecs[0] = '{1'b0, 32'h1003, 32'h0,        2'd0, 1'b1, 32'h80FF_FFFF, 0, 0, 0, 32'h1003, 4'h0, 32'h0,        32'hFFFF_FF80};
    vecs[1] = '{1'b1, 32'h2002, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0,         3, 2, 0, 32'h2002, 4'hC, 32'hBEEF_BEEF, 32'h0};
    vecs[2] = '{1'b0, 32'h3002, 32'h0,        2'd1, 1'b0, 32'h8001_1234, 1, 1, 4, 32'h3002, 4'h0, 32'h0,        32'h0000_8001};
    vecs[3] = '{1'b0, 32'h4000, 32'h0,        2'd2, 1'b0, 32'h1234_5678, 0, 2, 0, 32'h4000, 4'h0, 32'h0,        32'h1234_5678};
    vecs[4] = '{1'b1, 32'h5001, 32'h0000_00A5, 2'd0, 1'b0, 32'h0,         1, 0, 2, 32'h5001, 4'h2, 32'hA5A5_A5A5, 32'h0};
    vecs[5] = '{1'b0, 32'h6002, 32'h0,        2'd0, 1'b0, 32'h00C3_0000, 2, 0, 0, 32'h6002, 4'h0, 32'h0,        32'h0000_00C3};
    vecs[6] = '{1'b0, 32'h7000, 32'h0,        2'd1, 1'b1, 32'h0000_F00D, 0, 1, 0, 32'h7000, 4'h0, 32'h0,        32'hFFFF_F00D};
    vecs[7] = '{1'b1, 32'h8004, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0,         0, 0, 0, 32'h8004, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b1, 32'h9003, 32'h0000_0011, 2'd0, 1'b0, 32'h0,         0, 1, 0, 32'h9003, 4'h8, 32'h1111_1111, 32'h0};
    vecs[9] = '{1'b0, 32'hA001, 32'h0,        2'd0, 1'b1, 32'h1234_F678, 1, 0, 0, 32'hA001, 4'h0, 32'h0,        32'hFFFF_FFF6};

    // Reset state
    #2;
    chk("rst_valid", 32'(dreq_valid), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(addr_err_o), 32'd0);
    #10 resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Flush while waiting for data: access finishes, data dropped, no HOLD
    @(posedge clk); #1;
    d_valid_i = 1'b1; write_i = 1'b0; addr_i = 32'hA000; size_i = 2'd2; signed_i = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(dreq_valid), 32'd1);
    chk("fl_stall0", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    chk("fl_stall1", 32'(stall_o), 32'd1);
    chk("fl_valid_data", 32'(dreq_valid), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; d_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_stall2", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    dresp_data_ok = 1'b1; dresp_data = 32'h5555_AAAA;
    @(negedge clk);
    chk("fl_stall_end", 32'(stall_o), 32'd0);
    chk("fl_rdata", rdata_o, last_rdata);
    @(posedge clk); #1;
    d_valid_i = 1'b1; write_i = 1'b0; addr_i = 32'hB001; size_i = 2'd0; signed_i = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h0000_7F00; pipe_adv_i = 1'b1;
    @(negedge clk);
    chk("fr_valid", 32'(dreq_valid), 32'd1);
    chk("fr_addr", dreq_addr, 32'hB001);
    chk("fr_rdata", rdata_o, 32'h0000_007F);
    last_rdata = 32'h0000_007F;
    check_idle("fr_idle");

    // Reset while the request waits for addr_ok
    @(posedge clk); #1;
    d_valid_i = 1'b1; write_i = 1'b1; addr_i = 32'hC000; wdata_i = 32'h0102_0304;
    size_i = 2'd2; signed_i = 1'b0;
    @(negedge clk);
    chk("rs_valid", 32'(dreq_valid), 32'd1);
    chk("rs_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_addr_held", dreq_addr, 32'hC000);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    last_rdata = 32'h0;
    chk("rs_low_valid", 32'(dreq_valid), 32'd0);
    chk("rs_low_stall", 32'(stall_o), 32'd0);
    chk("rs_low_addr", dreq_addr, 32'd0);
    chk("rs_low_strb", 32'(dreq_strobe), 32'd0);
    chk("rs_low_data", dreq_data, 32'd0);
    chk("rs_low_rdata", rdata_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; pipe_adv_i = 1'b1;
    @(negedge clk);
    chk("rs_new_valid", 32'(dreq_valid), 32'd1);
    chk("rs_new_addr", dreq_addr, 32'hC000);
    chk("rs_new_strb", 32'(dreq_strobe), 32'hF);
    chk("rs_new_stall", 32'(stall_o), 32'd0);
    check_idle("rs_idle");

    // Misaligned word load
    @(posedge clk); #1;
    d_valid_i = 1'b1; write_i = 1'b0; addr_i = 32'h4002; size_i = 2'd2; signed_i = 1'b0;
`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    chk("ma_err", 32'(addr_err_o), 32'd1);
    chk("ma_valid", 32'(dreq_valid), 32'd0);
    chk("ma_stall", 32'(stall_o), 32'd0);
`else
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hAABB_CCDD; pipe_adv_i = 1'b1;
    @(negedge clk);
    chk("ma_err", 32'(addr_err_o), 32'd0);
    chk("ma_addr", dreq_addr, 32'h4000);
    chk("ma_rdata", rdata_o, 32'hAABB_CCDD);
    last_rdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    d_valid_i = 1'b1; write_i = 1'b1; addr_i = 32'h2001; wdata_i = 32'h0000_1234; size_i = 2'd1;
    @(negedge clk);
    chk("mh_addr", dreq_addr, 32'h2000);
    chk("mh_strb", 32'(dreq_strobe), 32'h3);
    chk("mh_data", dreq_data, 32'h1234_1234);
`endif
    check_idle("ma_idle");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
